// File: rtl/dac_sample_buf.sv
// dac_sample_buf: sample FIFO between a DDS stage and a DAC, primed before playback
// and drained at a fixed divided rate with sticky overflow/underflow flags.
module dac_sample_buf #(
   parameter int DEPTH_LOG2  = 4,
   parameter int DAC_DIV     = 16,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr_en,
   input  logic [13:0]           din,
   input  logic                  clr_status,
   output logic [13:0]           dac_data,
   output logic                  dac_wrt,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow
);
   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;
   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
   localparam cnt_t        DEPTH     = cnt_t'(2**DEPTH_LOG2);
   localparam cnt_t        PRIME_CNT = cnt_t'(PRIME_LEVEL);
   localparam logic [15:0] DIV_LAST  = 16'(DAC_DIV - 1);
   state_t      state, state_nx;
   logic [1:0]  rst_sync;
   logic        rst_i;
   logic [13:0] mem [2**DEPTH_LOG2];
   ptr_t        wr_ptr, rd_ptr;
   logic [15:0] div;
   logic        tick, pop, push, ovf_set, udf_set;
   // Reset asserts immediately but is released only on a clk edge.
   always_ff @(posedge clk or negedge rst)
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   assign rst_i = rst_sync[1];
   assign empty = count == '0;
   assign full  = count == DEPTH;
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = !enable                              ? IDLE  :
                 state == IDLE                        ? PRIME :
                 state == PRIME && count >= PRIME_CNT ? RUN   :
                 udf_set                              ? PRIME : state;
   end
   always_comb begin
      tick    = enable && state == RUN && div == DIV_LAST;
      pop     = tick && !empty;
      udf_set = tick && empty;
      push    = enable && wr_en && (!full || pop);
      ovf_set = enable && wr_en && full && !pop;
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         div       <= '0;
         dac_data  <= 14'h2000;
         dac_wrt   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         dac_wrt   <= pop;
         overflow  <= ovf_set | (overflow & ~clr_status);
         underflow <= udf_set | (underflow & ~clr_status);
         div       <= (state == RUN && enable && !tick) ? div + 16'd1 : 16'd0;
         if (pop) dac_data <= mem[rd_ptr];
         if (!enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + cnt_t'(push) - cnt_t'(pop);
         end
      end
endmodule

// File: tb/tb_dac_sample_buf.sv
// tb_dac_sample_buf: directed checks of priming, playback order, flags, disable and reset
// on a default instance and a PRIME_LEVEL=16 instance.
module tb_dac_sample_buf;
   logic        clk = 0, rst = 0, clr = 0;
   logic [13:0] din = '0;
   logic        a_en = 0, a_wr = 0, b_en = 0, b_wr = 0;
   logic [13:0] a_data, b_data;
   logic        a_wrt, a_full, a_empty, a_ovf, a_udf;
   logic        b_wrt, b_full, b_empty, b_ovf, b_udf;
   logic [4:0]  a_count, b_count;
   int          vecs = 0, errs = 0;
   always #5 clk = ~clk;
   dac_sample_buf u_a (.clk(clk), .rst(rst), .enable(a_en), .wr_en(a_wr), .din(din), .clr_status(clr),
      .dac_data(a_data), .dac_wrt(a_wrt), .full(a_full), .empty(a_empty), .count(a_count),
      .overflow(a_ovf), .underflow(a_udf));
   dac_sample_buf #(.PRIME_LEVEL(16)) u_b (.clk(clk), .rst(rst), .enable(b_en), .wr_en(b_wr), .din(din),
      .clr_status(clr), .dac_data(b_data), .dac_wrt(b_wrt), .full(b_full), .empty(b_empty),
      .count(b_count), .overflow(b_ovf), .underflow(b_udf));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wr_a(input logic [13:0] d);
      din = d; a_wr = 1; step(1); a_wr = 0;
   endtask
   task automatic wr_b(input logic [13:0] d);
      din = d; b_wr = 1; step(1); b_wr = 0;
   endtask
   task automatic wait_wrt_a(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         step(1);
         seen = a_wrt;
      end
      if (!seen) chk("wrt_timeout", 32'(a_wrt), 1);
   endtask
   function automatic logic [13:0] sv(input int i);
      return 14'(i * 293) ^ 14'h2aaa;
   endfunction
   initial begin
      step(3);
      chk("rst_data", 32'(a_data), 32'h2000);
      chk("rst_wrt", 32'(a_wrt), 0);
      chk("rst_empty", 32'(a_empty), 1);
      chk("rst_full", 32'(a_full), 0);
      chk("rst_count", 32'(a_count), 0);
      chk("rst_ovf", 32'(a_ovf), 0);
      chk("rst_udf", 32'(a_udf), 0);
      rst = 1;
      step(4);
      // overflow with 16-deep prime, then a write coinciding with the first tick
      b_en = 1;
      step(1);
      for (int k = 0; k < 16; k++) wr_b(14'(16'h1000 + k));
      chk("ovf_full", 32'(b_full), 1);
      chk("ovf_count16", 32'(b_count), 16);
      chk("ovf_pre", 32'(b_ovf), 0);
      wr_b(14'h1fff);
      chk("ovf_set", 32'(b_ovf), 1);
      chk("ovf_count", 32'(b_count), 16);
      clr = 1; step(1); clr = 0;
      chk("ovf_clr", 32'(b_ovf), 0);
      step(14);
      wr_b(14'h3abc);
      chk("sim_wrt", 32'(b_wrt), 1);
      chk("sim_data", 32'(b_data), 32'h1000);
      chk("sim_count", 32'(b_count), 16);
      chk("sim_ovf", 32'(b_ovf), 0);
      b_en = 0;
      step(1);
      chk("b_flush", 32'(b_count), 0);
      // prime and start
      a_en = 1;
      step(1);
      for (int k = 0; k < 8; k++) begin
         wr_a(14'(16'h0100 + k));
         if (k < 7) step(15);
      end
      chk("prime_count", 32'(a_count), 8);
      chk("prime_state", 32'(u_a.state), 1);
      step(1);
      chk("run_state", 32'(u_a.state), 2);
      step(15);
      chk("first_wrt_early", 32'(a_wrt), 0);
      step(1);
      chk("first_wrt", 32'(a_wrt), 1);
      chk("first_data", 32'(a_data), 32'h0100);
      for (int k = 1; k < 8; k++) begin
         step(16);
         chk("order_wrt", 32'(a_wrt), 1);
         chk("order_data", 32'(a_data), 32'h0100 + k);
      end
      chk("drained", 32'(a_count), 0);
      step(1);
      chk("wrt_single", 32'(a_wrt), 0);
      // underflow on the tick after the last sample
      step(15);
      chk("udf_wrt", 32'(a_wrt), 0);
      chk("udf_set", 32'(a_udf), 1);
      chk("udf_state", 32'(u_a.state), 1);
      chk("udf_hold", 32'(a_data), 32'h0107);
      clr = 1; step(1); clr = 0;
      chk("udf_clr", 32'(a_udf), 0);
      // disable mid-run
      for (int k = 0; k < 8; k++) wr_a(14'(16'h0200 + k));
      wait_wrt_a(40);
      chk("dis_pre", 32'(a_data), 32'h0200);
      a_en = 0;
      step(1);
      chk("dis_count", 32'(a_count), 0);
      chk("dis_hold", 32'(a_data), 32'h0200);
      chk("dis_state", 32'(u_a.state), 0);
      // asynchronous reset mid-run
      a_en = 1;
      step(1);
      for (int k = 0; k < 8; k++) wr_a(14'(16'h0300 + k));
      wait_wrt_a(40);
      chk("ar_pre", 32'(a_data), 32'h0300);
      #2 rst = 0;
      #1;
      chk("ar_data", 32'(a_data), 32'h2000);
      chk("ar_count", 32'(a_count), 0);
      chk("ar_wrt", 32'(a_wrt), 0);
      chk("ar_empty", 32'(a_empty), 1);
      chk("ar_ovf", 32'(a_ovf), 0);
      chk("ar_udf", 32'(a_udf), 0);
      step(2);
      rst = 1;
      step(4);
      // long stream through many pointer wraps
      for (int j = 0; j < 8; j++) wr_a(sv(j));
      for (int i = 0; i < 100; i++) begin
         wait_wrt_a(40);
         chk("stream", 32'(a_data), 32'(sv(i)));
         if (i + 8 < 100) wr_a(sv(i + 8));
      end
      chk("stream_ovf", 32'(a_ovf), 0);
      chk("stream_udf", 32'(a_udf), 0);
      chk("stream_count", 32'(a_count), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
